// File: rtl/scroll_pkg.sv
// Shared constants and types for the scroll controller.
// The lane widths are fixed package constants, so the lane-state struct
// has the same layout wherever it is used.
package scroll_pkg;

  localparam int PAN_W  = 9;              // integer pan width in pixels
  localparam int FRAC_W = 4;              // fractional bits of the accumulator
  localparam int VEL_W  = 8;              // signed velocity width
  localparam int ACC_W  = PAN_W + FRAC_W; // accumulator width
  localparam int SUM_W  = ACC_W + 2;      // headroom for the signed bounce test

  // Register offsets within a layer's 4-word window
  localparam logic [1:0] REG_VEL     = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_LIMIT   = 2'd2;
  localparam logic [1:0] REG_LOADPOS = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_BOUNCE_BIT = 1;

  typedef struct packed {
    logic [VEL_W-1:0] vel;
    logic             enable;
    logic             bounce;
    logic [PAN_W-1:0] limit;
    logic [ACC_W-1:0] acc;
    logic             pending;
  } lane_state_t;

  // Two's-complement negate; the most-negative value saturates to max positive.
  function automatic logic [VEL_W-1:0] negate_sat(input logic [VEL_W-1:0] v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}}) return {1'b0, {(VEL_W-1){1'b1}}};
    return ~v + VEL_W'(1);
  endfunction

endpackage

// File: rtl/scroll_if.sv
// Register-write bus of the scroll controller.
// With SCROLL_READBACK_EN defined, adds the read strobe and read data.
interface scroll_if #(parameter int NUM_LAYERS = 2);

  localparam int ADDR_W = $clog2(NUM_LAYERS) + 2;

  logic              regWrite;
  logic [ADDR_W-1:0] regAddr;
  logic [15:0]       regData;
`ifdef SCROLL_READBACK_EN
  logic              regRead;
  logic [15:0]       regRdData;
`endif

  modport master (
    output regWrite, regAddr, regData
`ifdef SCROLL_READBACK_EN
    , output regRead, input regRdData
`endif
  );

  modport slave (
    input regWrite, regAddr, regData
`ifdef SCROLL_READBACK_EN
    , input regRead, output regRdData
`endif
  );

endinterface

// File: rtl/scroll_lane.sv
// One scroll lane: shadow registers, position accumulator, wrap/bounce.
// Active VEL/CTRL/LIMIT are consumed only on the commit cycle, where they
// equal the register values held before that cycle, so one register set
// serves as both shadow and active copy.
// SCROLL_READBACK_EN adds a combinational read word for the top-level mux.
module scroll_lane
  import scroll_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync_i,
  input  logic             wr_en_i,
  input  logic [1:0]       offset_i,
  input  logic [PAN_W-1:0] wr_data_i,
  output logic [PAN_W-1:0] pan_o
`ifdef SCROLL_READBACK_EN
  ,
  output logic [15:0]      rd_word_o
`endif
);

  lane_state_t      state_q, state_d;
  logic [PAN_W-1:0] loadpos_q, loadpos_d;

  logic             wr_vel, wr_ctrl, wr_limit, wr_load;
  logic [SUM_W-1:0] next_pos;
  logic [SUM_W-1:0] limit_fx;
  logic             next_neg, next_over;

  // Write decode and the candidate next position for this frame
  always_comb begin
    wr_vel    = wr_en_i && (offset_i == REG_VEL);
    wr_ctrl   = wr_en_i && (offset_i == REG_CTRL);
    wr_limit  = wr_en_i && (offset_i == REG_LIMIT);
    wr_load   = wr_en_i && (offset_i == REG_LOADPOS);
    next_pos  = {2'b00, state_q.acc}
              + {{(SUM_W-VEL_W){state_q.vel[VEL_W-1]}}, state_q.vel};
    limit_fx  = {2'b00, state_q.limit, {FRAC_W{1'b0}}};
    next_neg  = next_pos[SUM_W-1];
    next_over = !next_neg && (next_pos > limit_fx);
  end

  // Frame commit first, then register writes, so a coincident write wins
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    loadpos_d = loadpos_q;
    if (vsync_i) begin
      if (state_q.pending) begin
        state_d.acc     = {loadpos_q, {FRAC_W{1'b0}}};
        state_d.pending = 1'b0;
      end else if (state_q.enable) begin
        if (!state_q.bounce) begin
          state_d.acc = next_pos[ACC_W-1:0];
        end else if (next_neg) begin
          state_d.acc = '0;
          state_d.vel = negate_sat(state_q.vel);
        end else if (next_over) begin
          state_d.acc = limit_fx[ACC_W-1:0];
          state_d.vel = negate_sat(state_q.vel);
        end else begin
          state_d.acc = next_pos[ACC_W-1:0];
        end
      end
    end
    if (wr_vel)   state_d.vel = wr_data_i[VEL_W-1:0];
    if (wr_ctrl) begin
      state_d.enable = wr_data_i[CTRL_ENABLE_BIT];
      state_d.bounce = wr_data_i[CTRL_BOUNCE_BIT];
    end
    if (wr_limit) state_d.limit = wr_data_i;
    if (wr_load) begin
      loadpos_d       = wr_data_i;
      state_d.pending = 1'b1;
    end
  end

  // Lane state registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      state_q   <= '0;
      loadpos_q <= '0;
    end else begin
      state_q   <= state_d;
      loadpos_q <= loadpos_d;
    end
  end

  assign pan_o = state_q.acc[ACC_W-1:FRAC_W];

`ifdef SCROLL_READBACK_EN
  // Read word for the selected offset
  always_comb begin
    rd_word_o = '0;
    case (offset_i)
      REG_VEL:     rd_word_o = {{(16-VEL_W){state_q.vel[VEL_W-1]}}, state_q.vel};
      REG_CTRL:    rd_word_o = {14'b0, state_q.bounce, state_q.enable};
      REG_LIMIT:   rd_word_o = {{(16-PAN_W){1'b0}}, state_q.limit};
      REG_LOADPOS: rd_word_o = {state_q.pending, 6'b0, state_q.acc[ACC_W-1:FRAC_W]};
      default:     rd_word_o = '0;
    endcase
  end
`endif

endmodule

// File: rtl/scroll_controller.sv
// Per-layer scroll-position generator for the background layer pan inputs.
// Holds address decode, the frame counter, pan packing and, with
// SCROLL_READBACK_EN defined, the registered readback mux.
// Lane widths come from scroll_pkg; NUM_LAYERS must be at least 2.
module scroll_controller
  import scroll_pkg::*;
#(
  parameter int NUM_LAYERS = 2
) (
  input  logic                        clkPixel,
  input  logic                        resetN,
  input  logic                        vsyncStarting,
  scroll_if.slave                     bus,
  output logic [NUM_LAYERS*PAN_W-1:0] pan,
  output logic [15:0]                 frameCount
);

  localparam int LAYER_W = $clog2(NUM_LAYERS);
  localparam int ADDR_W  = LAYER_W + 2;

  logic [LAYER_W-1:0] layer;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               unused_data_bits;

  assign layer = bus.regAddr[ADDR_W-1:2];
  // Upper data bits carry no register field
  assign unused_data_bits = ^bus.regData[15:PAN_W];

`ifdef SCROLL_READBACK_EN
  logic [15:0] lane_rd [NUM_LAYERS];
`endif

  // Layers at or beyond NUM_LAYERS match no lane, so their writes are dropped
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lane
    logic wr_en;
    assign wr_en = bus.regWrite && (layer == LAYER_W'(i));

    scroll_lane u_lane (
      .clk       (clkPixel),
      .rst_n     (resetN),
      .vsync_i   (vsyncStarting),
      .wr_en_i   (wr_en),
      .offset_i  (bus.regAddr[1:0]),
      .wr_data_i (bus.regData[PAN_W-1:0]),
      .pan_o     (pan[i*PAN_W +: PAN_W])
`ifdef SCROLL_READBACK_EN
      ,
      .rd_word_o (lane_rd[i])
`endif
    );
  end

  // Frame counter advances on each frame strobe and wraps naturally
  always_comb begin
    frame_count_d = vsyncStarting ? frame_count_q + 16'd1 : frame_count_q;
  end

  // Frame counter register
  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) frame_count_q <= '0;
    else         frame_count_q <= frame_count_d;
  end

  assign frameCount = frame_count_q;

`ifdef SCROLL_READBACK_EN
  logic [15:0] rd_data_q, rd_data_d;

  // Capture the addressed word on a read; hold it otherwise
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.regRead) begin
      rd_data_d = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (layer == LAYER_W'(i)) rd_data_d = lane_rd[i];
      end
    end
  end

  // Read data register
  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign bus.regRdData = rd_data_q;
`endif

endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- Per-layer scroll-position generator feeding the background layer stage's pan inputs. Replaces the fixed per-frame pan increment.
- Each layer has a fractional position accumulator. The accumulator advances by a programmable signed velocity once per frame, on vsyncStarting.
- Per-layer modes: wrap or bounce-between-limits.
- Register writes land in shadow registers and commit atomically at the frame boundary, so panning never tears mid-frame.

Parameters:
- NUM_LAYERS, 2, number of independent scroll lanes.
- PAN_W, 9, integer pan width in pixels.
- FRAC_W, 4, fractional bits; velocity unit is 1/2^FRAC_W px/frame.
- VEL_W, 8, signed velocity width.

Ports:
- clkPixel  in  1  pixel clock; sole clock.
- resetN  in  1  asynchronous active-low reset.
- vsyncStarting  in  1  one-cycle frame-boundary strobe from the frame generator.
- regWrite  in  1  write strobe; one write per asserted cycle.
- regAddr  in  $clog2(NUM_LAYERS)+2  bits [1:0] select the register, upper bits select the layer.
- regData  in  16  write data.
- pan  out  NUM_LAYERS*PAN_W  lane i at pan[i*PAN_W +: PAN_W]; registered.
- frameCount  out  16  frames elapsed since reset.

Behaviour:
- Registers per layer:
  - Offset 0: VEL, signed, regData[VEL_W-1:0].
  - Offset 1: CTRL. [0] enable, [1] bounce (0 = wrap).
  - Offset 2: LIMIT, regData[PAN_W-1:0]. Upper bound for bounce.
  - Offset 3: LOADPOS, regData[PAN_W-1:0]. Sets the load-pending flag.
  - Writes to a layer index >= NUM_LAYERS are ignored.
- Reset (async assert, sync-release safe): all shadow and active registers, accumulators, pending flags, pan and frameCount go to 0.
- Commit on the cycle vsyncStarting=1:
  - Active VEL/CTRL/LIMIT take the shadow values as they stood before that cycle.
  - A write in the same cycle updates the shadow only and takes effect at the next vsync.
- Accumulator update in the same commit cycle, acc width PAN_W+FRAC_W:
  - If load pending: acc = LOADPOS<<FRAC_W; pending cleared. This takes priority over velocity.
  - A LOADPOS write coincident with vsync applies the old pending value, if any, and leaves the new value pending.
  - Else if enable=0: acc unchanged.
  - Else next = acc + sign-extended velocity (active value committed this cycle).
    - Wrap mode: acc = next mod 2^(PAN_W+FRAC_W).
    - Bounce mode: evaluate next as signed PAN_W+FRAC_W+2 bits.
      - If next > LIMIT<<FRAC_W: acc = LIMIT<<FRAC_W and velocity negated.
      - If next < 0: acc = 0 and velocity negated.
      - Negating the most-negative velocity saturates to the max positive value.
      - The negated velocity is written back to both active and shadow VEL, unless a VEL write occurs that same cycle; the write wins.
- pan lane = acc[PAN_W+FRAC_W-1:FRAC_W], registered. It is valid the cycle after vsyncStarting and held constant for the whole frame.
- frameCount increments on each vsyncStarting, wraps at 0xFFFF→0, and has the same one-cycle latency.
- vsyncStarting held high for multiple cycles: one update per high cycle (caller guarantees single-cycle pulses).

Optional Feature:
- Macro SCROLL_READBACK_EN.
- Defined: adds ports regRead in 1 and regRdData out 16.
  - Registered read data is valid one cycle after regRead.
  - Offsets 0–2 return the shadow value, zero-extended; VEL is sign-extended.
  - Offset 3 returns {pending, 6'b0, current integer position}.
  - Reads have no side effects; regRdData holds its value between reads.
- Undefined: no read ports or read mux; write-only interface.

Decomposition:
- Package scroll_pkg: register offset constants (REG_VEL, REG_CTRL, REG_LIMIT, REG_LOADPOS), CTRL bit positions, and a lane-state struct typedef (vel, enable, bounce, limit, acc, pending).
- Sub-module scroll_lane, instantiated NUM_LAYERS times. Holds one lane's shadow/active registers, accumulator and bounce logic.
- The top level holds address decode, frameCount, output packing and the optional readback mux.

Test Plan:
- Reset: drive resetN low mid-frame with nonzero positions → pan=0 and frameCount=0 immediately. After release, with no writes and 3 vsyncs → pan stays 0 and frameCount=3.
- Integer scroll: L0 VEL=0x10, CTRL=1; 3 vsyncs → pan0 = 1, 2, 3, each one cycle after the strobe; pan1=0 throughout.
- Fractional: L1 VEL=0x08, enable; 4 vsyncs → pan1 = 0, 1, 1, 2. VEL=0xF8 then 2 more vsyncs → 1, 1.
- Wrap and load: L0 LOADPOS=511, VEL=0x10; vsync → 511 (load wins over velocity); vsync → 0.
- Bounce: L0 LIMIT=4, VEL=0x30, bounce+enable; 4 vsyncs → 3, 4 (vel becomes 0xD0), 1, 0 (vel becomes 0x30).
- Write/vsync collision: write VEL=0x20 on the same cycle as vsync while the old VEL=0x10 → that frame advances by 1, the next by 2. With SCROLL_READBACK_EN, read offset 0 → 0x0020.
